heap_move_sequencer: RTL and testbench
======================================

# heap_move_sequencer

Multi-cycle sequencer for the Zero VM `moveLong` instruction. It copies a run of elements from one heap array to another, one element at a time, over a single-port heap with synchronous read. It also keeps the array-size table up to date. The instruction decoder starts it and stalls `ip` until `done`, so wide per-instruction copy loops are no longer needed in the executor.

## Interface
Parameters:
- `MemoryElementWidth`, 12, width of heap elements, addresses, indices and sizes
- `NArea`, 10, elements per array area
- `NArrays`, 2, number of arrays
- `NHeap`, 20, heap depth (`NArea*NArrays`)

Ports:
- `clock` in 1: the single clock, rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: request pulse, sampled only in IDLE
- `srcArray`, `srcOffset`, `tgtArray`, `tgtOffset`, `length` in MemoryElementWidth: copy operands, captured when `start` is accepted
- `busy` out 1: high from the accepting edge until the DONE state exits
- `done` out 1: one-cycle pulse at completion
- `error` out 1: valid with `done`; high when the copy was rejected
- `heapRdAddr` out MemoryElementWidth: heap read address; data returns the next cycle
- `heapRdData` in MemoryElementWidth: heap read data
- `heapWrEn` out 1, `heapWrAddr` out MemoryElementWidth, `heapWrData` out MemoryElementWidth: heap write port
- `sizeRdArray` out MemoryElementWidth: array whose size is read; always drives the latched `tgtArray`
- `sizeRdData` in MemoryElementWidth: combinational size read
- `sizeWrEn` out 1, `sizeWrValue` out MemoryElementWidth: size-table write for `sizeRdArray`

Reset values: `busy`, `done`, `error`, `heapWrEn` and `sizeWrEn` are 0; all address and data outputs are 0; state is IDLE.

## Operation
- Operation states: IDLE, CHECK, READ, WRITE, DONE.
- **IDLE:** on `start`, latch the operands, clear counter `k`, go to CHECK. `start` in any other state is ignored, not queued.
- **CHECK:**
  - Error if `srcArray >= NArrays`, `tgtArray >= NArrays`, `srcOffset+length > NArea` or `tgtOffset+length > NArea`.
  - On error, or if `length==0`, go to DONE with no heap or size writes.
  - Otherwise go to READ.
  - Sums are computed one bit wider than MemoryElementWidth so they cannot wrap.
- **Direction:** backward if `srcArray==tgtArray` and `tgtOffset > srcOffset`, otherwise forward. This gives memmove semantics; overlapping runs copy correctly.
- **Element index:**
  - Forward: `e = k`.
  - Backward: `e = length-1-k`.
- **READ:** `heapRdAddr = srcArray*NArea + srcOffset + e`; go to WRITE.
- **WRITE:**
  - `heapWrEn=1`, `heapWrAddr = tgtArray*NArea + tgtOffset + e`, `heapWrData = heapRdData`.
  - If `sizeRdData < tgtOffset+e+1`, assert `sizeWrEn` with `sizeWrValue = tgtOffset+e+1`.
  - Then `k++`. Go to DONE if `k == length-1` (last element), else READ.
- **DONE:** assert `done` (and `error` if rejected) for one cycle, drop `busy`, go to IDLE.
- Write strobes are asserted only in WRITE. Data outputs hold their last value otherwise.
- **Reset mid-operation:** abandon immediately, return to IDLE, no further writes, no `done`. Writes already performed are not undone.

## Timing
- `start` accepted at edge T → CHECK at T+1.
- Element k: read at T+2+2k, written at T+3+2k.
- `done` is asserted in cycle T+2+2·length; `busy` is low from T+3+2·length.
- `length==0` or error: `done` in cycle T+2, no writes.
- Throughput: 2 cycles per element plus 3 cycles of overhead (including DONE).
- Back-to-back: a `start` in the cycle after DONE is accepted.
- The size read/write always concerns the latched `tgtArray`, so updates are coherent within one WRITE cycle.

## Structure
- Shared package `zero_heap_pkg` holds:
  - constants `MemoryElementWidth`, `NArea`, `NArrays`, `NHeap`
  - the state typedef `heap_move_state_t`
- One natural sub-module, `heap_address`: combinational `array*NArea + offset + e`. It is instantiated twice (source and target).
- The heap memory and size table are outside the block.

## Test plan
- Array 0 = 0..9, array 1 = 100..109, both size 10. Copy src 0/4 → tgt 1/2, length 3, start at T:
  - array 1 becomes 100,101,4,5,6,105..109
  - size stays 10, no `sizeWrEn`
  - `done` at T+8, `error`=0
- Target array 1 has size 0. Copy length 3 to offset 2:
  - `sizeWrEn` with 3, 4, 5
  - final size 5
- Overlap within array 0 (0..9). Copy 0 → 2, length 5:
  - backward order, write addresses 6,5,4,3,2
  - result 0,1,0,1,2,3,4,7,8,9
- `length==0`:
  - `done` at T+2, `error`=0, no writes
- Range errors, each expecting `done`+`error` at T+2 and zero writes:
  - `srcOffset=8`, `length=3`
  - `tgtArray=2`
- Robustness:
  - `reset` asserted after the second WRITE: only 2 elements written, no `done`, IDLE next cycle.
  - `start` asserted while busy is ignored.

Source files
------------

// File: rtl/zero_heap_pkg.sv
// Shared constants and state type for the Zero VM heap datapath.
package zero_heap_pkg;

    localparam int MemoryElementWidth = 12;
    localparam int NArea              = 10;
    localparam int NArrays            = 2;
    localparam int NHeap              = NArea * NArrays;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } heap_move_state_t;

endpackage

// File: rtl/heap_address.sv
// Flat heap address of one element: arrayIdx*AreaSize + offset + element.
module heap_address
    import zero_heap_pkg::*;
#(
    parameter int Width    = MemoryElementWidth,
    parameter int AreaSize = NArea
) (
    input  logic [Width-1:0] arrayIdx,
    input  logic [Width-1:0] offset,
    input  logic [Width-1:0] element,
    output logic [Width-1:0] addr
);

    localparam logic [Width-1:0] AreaStride = Width'(AreaSize);

    assign addr = arrayIdx * AreaStride + offset + element;

endmodule

// File: rtl/heap_move_sequencer.sv
// moveLong sequencer: copies a run of heap elements one at a time over a
// single-port synchronous-read heap, with memmove ordering, and grows the
// target array's size entry as elements land past its current end.
module heap_move_sequencer #(
    parameter int MemoryElementWidth = zero_heap_pkg::MemoryElementWidth,
    parameter int NArea              = zero_heap_pkg::NArea,
    parameter int NArrays            = zero_heap_pkg::NArrays,
    parameter int NHeap              = zero_heap_pkg::NHeap
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [MemoryElementWidth-1:0] srcArray,
    input  logic [MemoryElementWidth-1:0] srcOffset,
    input  logic [MemoryElementWidth-1:0] tgtArray,
    input  logic [MemoryElementWidth-1:0] tgtOffset,
    input  logic [MemoryElementWidth-1:0] length,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [MemoryElementWidth-1:0] heapRdAddr,
    input  logic [MemoryElementWidth-1:0] heapRdData,
    output logic                          heapWrEn,
    output logic [MemoryElementWidth-1:0] heapWrAddr,
    output logic [MemoryElementWidth-1:0] heapWrData,
    output logic [MemoryElementWidth-1:0] sizeRdArray,
    input  logic [MemoryElementWidth-1:0] sizeRdData,
    output logic                          sizeWrEn,
    output logic [MemoryElementWidth-1:0] sizeWrValue
);
    import zero_heap_pkg::*;

    localparam int W = MemoryElementWidth;
    localparam logic [W-1:0] One        = W'(1);
    localparam logic [W-1:0] ArrayLimit = W'(NArrays);
    localparam logic [W:0]   AreaLimit  = (W + 1)'(NArea);

    // The heap is assumed to be exactly the concatenation of all array areas.
    if (NHeap != NArea * NArrays) begin : g_geometry_bad
        $error("heap_move_sequencer: NHeap must equal NArea*NArrays");
    end

    heap_move_state_t state;

    logic [W-1:0] srcArrayR, srcOffsetR, tgtArrayR, tgtOffsetR, lengthR;
    logic [W-1:0] k;
    logic [W-1:0] e;
    logic         backward;
    logic [W-1:0] wrDataHold;
    logic [W-1:0] sizeValHold;

    logic [W:0]   srcEnd, tgtEnd;
    logic         rejected;
    logic [W-1:0] eFirst, eStep, eRead;
    logic [W-1:0] srcAddr, tgtAddr;
    logic [W-1:0] sizeTarget;

    // Operand validation; sums carry one extra bit so they cannot wrap.
    assign srcEnd   = {1'b0, srcOffsetR} + {1'b0, lengthR};
    assign tgtEnd   = {1'b0, tgtOffsetR} + {1'b0, lengthR};
    assign rejected = (srcArrayR >= ArrayLimit) || (tgtArrayR >= ArrayLimit) ||
                      (srcEnd > AreaLimit) || (tgtEnd > AreaLimit);

    // Element walk: the read address is always registered one step ahead,
    // so the source address is formed from the element about to be read.
    assign eFirst = backward ? (lengthR - One) : '0;
    assign eStep  = backward ? (e - One) : (e + One);
    assign eRead  = (state == S_CHECK) ? eFirst : eStep;

    heap_address #(.Width(W), .AreaSize(NArea)) u_src_addr (
        .arrayIdx (srcArrayR),
        .offset   (srcOffsetR),
        .element  (eRead),
        .addr     (srcAddr)
    );

    heap_address #(.Width(W), .AreaSize(NArea)) u_tgt_addr (
        .arrayIdx (tgtArrayR),
        .offset   (tgtOffsetR),
        .element  (e),
        .addr     (tgtAddr)
    );

    // Write data and size update depend on same-cycle inputs (heap read
    // data, size table read), so they pass through during WRITE and hold
    // the last written value otherwise.
    assign sizeTarget  = tgtOffsetR + e + One;
    assign sizeRdArray = tgtArrayR;
    assign sizeWrEn    = (state == S_WRITE) && (sizeRdData < sizeTarget);
    assign sizeWrValue = (state == S_WRITE) ? sizeTarget : sizeValHold;
    assign heapWrData  = (state == S_WRITE) ? heapRdData : wrDataHold;

    // Control FSM with registered status, strobe and address outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            heapWrEn    <= 1'b0;
            heapRdAddr  <= '0;
            heapWrAddr  <= '0;
            wrDataHold  <= '0;
            sizeValHold <= '0;
            srcArrayR   <= '0;
            srcOffsetR  <= '0;
            tgtArrayR   <= '0;
            tgtOffsetR  <= '0;
            lengthR     <= '0;
            k           <= '0;
            e           <= '0;
            backward    <= 1'b0;
        end else begin
            done     <= 1'b0;
            heapWrEn <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        srcArrayR  <= srcArray;
                        srcOffsetR <= srcOffset;
                        tgtArrayR  <= tgtArray;
                        tgtOffsetR <= tgtOffset;
                        lengthR    <= length;
                        backward   <= (srcArray == tgtArray) && (tgtOffset > srcOffset);
                        k          <= '0;
                        busy       <= 1'b1;
                        error      <= 1'b0;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (rejected || (lengthR == '0)) begin
                        done  <= 1'b1;
                        error <= rejected;
                        state <= S_DONE;
                    end else begin
                        e          <= eFirst;
                        heapRdAddr <= srcAddr;
                        state      <= S_READ;
                    end
                end
                S_READ: begin
                    heapWrEn   <= 1'b1;
                    heapWrAddr <= tgtAddr;
                    state      <= S_WRITE;
                end
                S_WRITE: begin
                    wrDataHold  <= heapRdData;
                    sizeValHold <= sizeTarget;
                    k           <= k + One;
                    if (k == lengthR - One) begin
                        done  <= 1'b1;
                        error <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        e          <= eStep;
                        heapRdAddr <= srcAddr;
                        state      <= S_READ;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    error <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_heap_move_sequencer.sv
// Self-checking bench for heap_move_sequencer with a heap/size-table model
// and a memmove reference computed from the copy rules.
module tb_heap_move_sequencer;
    import zero_heap_pkg::*;

    localparam int W = MemoryElementWidth;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] srcArray = '0, srcOffset = '0, tgtArray = '0, tgtOffset = '0, length = '0;
    logic         busy, done, error, heapWrEn, sizeWrEn;
    logic [W-1:0] heapRdAddr, heapWrAddr, heapWrData, sizeRdArray, sizeWrValue;
    logic [W-1:0] heapRdData = '0;
    logic [W-1:0] sizeRdData;

    logic [W-1:0] heap    [NHeap];
    logic [W-1:0] sizeTab [NArrays];
    int           refHeap [NHeap];
    int           refSize [NArrays];
    int           wrLog[$];
    int           sizeLog[$];
    int           doneCount = 0;
    int           total = 0;
    int           bad = 0;

    always #5 clock = ~clock;

    heap_move_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .srcArray    (srcArray),
        .srcOffset   (srcOffset),
        .tgtArray    (tgtArray),
        .tgtOffset   (tgtOffset),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .heapRdAddr  (heapRdAddr),
        .heapRdData  (heapRdData),
        .heapWrEn    (heapWrEn),
        .heapWrAddr  (heapWrAddr),
        .heapWrData  (heapWrData),
        .sizeRdArray (sizeRdArray),
        .sizeRdData  (sizeRdData),
        .sizeWrEn    (sizeWrEn),
        .sizeWrValue (sizeWrValue)
    );

    assign sizeRdData = (int'(sizeRdArray) < NArrays) ? sizeTab[int'(sizeRdArray)] : '0;

    // External heap, size table and write/done monitors.
    always @(posedge clock) begin
        if (int'(heapRdAddr) < NHeap) heapRdData <= heap[int'(heapRdAddr)];
        if (heapWrEn && int'(heapWrAddr) < NHeap) heap[int'(heapWrAddr)] <= heapWrData;
        if (sizeWrEn && int'(sizeRdArray) < NArrays) sizeTab[int'(sizeRdArray)] <= sizeWrValue;
        if (heapWrEn) wrLog.push_back(int'(heapWrAddr));
        if (sizeWrEn) sizeLog.push_back(int'(sizeWrValue));
        if (done) doneCount++;
    end

    task automatic set_mem();
        for (int i = 0; i < NArea; i++) begin
            heap[i] = W'(i);           refHeap[i] = i;
            heap[NArea + i] = W'(100 + i); refHeap[NArea + i] = 100 + i;
        end
        for (int a = 0; a < NArrays; a++) begin
            sizeTab[a] = W'(NArea); refSize[a] = NArea;
        end
    endtask

    task automatic rand_mem();
        for (int i = 0; i < NHeap; i++) begin
            refHeap[i] = int'($urandom_range(0, 4095));
            heap[i] = W'(refHeap[i]);
        end
        for (int a = 0; a < NArrays; a++) begin
            refSize[a] = int'($urandom_range(0, 12));
            sizeTab[a] = W'(refSize[a]);
        end
    endtask

    // One copy: reference result from memmove rules, then drive and compare.
    // Entered just after a falling edge in an idle cycle.
    task automatic run_move(input int sa, input int so, input int ta, input int to,
                            input int len, input bit poke);
        bit expErr, bwd, seen, ok;
        int expLat, n, cur, dc0, idx;
        int tmp[$];
        int expWr[$];
        int expSz[$];
        expErr = (sa >= NArrays) || (ta >= NArrays) || (so + len > NArea) || (to + len > NArea);
        expLat = (expErr || len == 0) ? 2 : 2 + 2 * len;
        if (!expErr && len > 0) begin
            bwd = (sa == ta) && (to > so);
            for (int i = 0; i < len; i++) tmp.push_back(refHeap[sa * NArea + so + i]);
            cur = refSize[ta];
            for (int j = 0; j < len; j++) begin
                idx = bwd ? len - 1 - j : j;
                expWr.push_back(ta * NArea + to + idx);
                if (cur < to + idx + 1) begin
                    expSz.push_back(to + idx + 1);
                    cur = to + idx + 1;
                end
            end
            for (int i = 0; i < len; i++) refHeap[ta * NArea + to + i] = tmp[i];
            refSize[ta] = cur;
        end

        wrLog.delete();
        sizeLog.delete();
        dc0 = doneCount;
        srcArray = W'(sa); srcOffset = W'(so); tgtArray = W'(ta); tgtOffset = W'(to); length = W'(len);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        seen = 1'b0;
        for (n = 1; n <= 60; n++) begin
            @(negedge clock);
            if (poke) begin
                if (n >= 2 && n <= 4) begin
                    start = 1'b1; srcArray = 1; srcOffset = 0; tgtArray = 0; tgtOffset = 3; length = 6;
                end else begin
                    start = 1'b0;
                end
            end
            if (n == 1) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++; $display("FAIL busy_after_accept: got %b expected 1", busy);
                end
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        total++;
        if (!seen) begin
            bad++; $display("FAIL done_timeout: no done within 60 cycles, expected at T+%0d", expLat);
        end else if (n != expLat) begin
            bad++; $display("FAIL done_latency: got T+%0d expected T+%0d", n, expLat);
        end
        total++;
        if (error !== expErr) begin
            bad++; $display("FAIL error_flag: got %b expected %b", error, expErr);
        end
        @(negedge clock);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL busy_release: busy=%b done=%b expected 0/0", busy, done);
        end
        total++;
        ok = (wrLog.size() == expWr.size());
        for (int i = 0; ok && i < expWr.size(); i++) if (wrLog[i] != expWr[i]) ok = 1'b0;
        if (!ok) begin
            bad++; $display("FAIL write_addr_seq: got %0d writes %p expected %0d writes %p",
                            wrLog.size(), wrLog, expWr.size(), expWr);
        end
        total++;
        ok = (sizeLog.size() == expSz.size());
        for (int i = 0; ok && i < expSz.size(); i++) if (sizeLog[i] != expSz[i]) ok = 1'b0;
        if (!ok) begin
            bad++; $display("FAIL size_write_seq: got %p expected %p", sizeLog, expSz);
        end
        total++;
        for (int i = 0; i < NHeap; i++) begin
            if (heap[i] !== W'(refHeap[i])) begin
                bad++; $display("FAIL heap_contents: addr %0d got %0d expected %0d", i, heap[i], refHeap[i]);
                break;
            end
        end
        total++;
        for (int a = 0; a < NArrays; a++) begin
            if (sizeTab[a] !== W'(refSize[a])) begin
                bad++; $display("FAIL size_table: array %0d got %0d expected %0d", a, sizeTab[a], refSize[a]);
                break;
            end
        end
        total++;
        if (doneCount != dc0 + 1) begin
            bad++; $display("FAIL done_pulse_count: got %0d expected 1", doneCount - dc0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            bad++; $display("FAIL reset_status: busy=%b done=%b error=%b expected 0/0/0", busy, done, error);
        end
        total++;
        if (heapWrEn !== 1'b0 || sizeWrEn !== 1'b0) begin
            bad++; $display("FAIL reset_strobes: heapWrEn=%b sizeWrEn=%b expected 0/0", heapWrEn, sizeWrEn);
        end
        total++;
        if (heapRdAddr !== '0 || heapWrAddr !== '0 || heapWrData !== '0 || sizeWrValue !== '0 || sizeRdArray !== '0) begin
            bad++; $display("FAIL reset_outputs: rd=%0d wra=%0d wrd=%0d szv=%0d sza=%0d expected all 0",
                            heapRdAddr, heapWrAddr, heapWrData, sizeWrValue, sizeRdArray);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic_copy();
        int expA1[NArea] = '{100, 101, 4, 5, 6, 105, 106, 107, 108, 109};
        set_mem();
        run_move(0, 4, 1, 2, 3, 1'b0);
        total++;
        for (int i = 0; i < NArea; i++) begin
            if (heap[NArea + i] !== W'(expA1[i])) begin
                bad++; $display("FAIL basic_array1: index %0d got %0d expected %0d", i, heap[NArea + i], expA1[i]);
                break;
            end
        end
    endtask

    task automatic test_size_grow();
        set_mem();
        sizeTab[1] = '0; refSize[1] = 0;
        run_move(0, 0, 1, 2, 3, 1'b0);
        total++;
        if (sizeLog.size() != 3 || sizeLog[0] != 3 || sizeLog[1] != 4 || sizeLog[2] != 5 || sizeTab[1] !== W'(5)) begin
            bad++; $display("FAIL size_grow: log %p final %0d expected 3,4,5 final 5", sizeLog, sizeTab[1]);
        end
    endtask

    task automatic test_overlap();
        int expA0[NArea] = '{0, 1, 0, 1, 2, 3, 4, 7, 8, 9};
        set_mem();
        run_move(0, 0, 0, 2, 5, 1'b0);
        total++;
        if (wrLog.size() != 5 || wrLog[0] != 6 || wrLog[1] != 5 || wrLog[2] != 4 || wrLog[3] != 3 || wrLog[4] != 2) begin
            bad++; $display("FAIL overlap_order: got %p expected 6,5,4,3,2", wrLog);
        end
        total++;
        for (int i = 0; i < NArea; i++) begin
            if (heap[i] !== W'(expA0[i])) begin
                bad++; $display("FAIL overlap_result: index %0d got %0d expected %0d", i, heap[i], expA0[i]);
                break;
            end
        end
    endtask

    task automatic test_zero_and_errors();
        set_mem();
        run_move(0, 3, 1, 5, 0, 1'b0);
        run_move(0, 8, 1, 0, 3, 1'b0);
        run_move(0, 0, 2, 0, 3, 1'b0);
        run_move(3, 0, 1, 0, 2, 1'b0);
        run_move(0, 0, 1, 9, 2, 1'b0);
        run_move(0, 0, 1, 0, 10, 1'b0);
    endtask

    task automatic test_reset_mid();
        int n, dc0;
        set_mem();
        wrLog.delete();
        dc0 = doneCount;
        srcArray = 0; srcOffset = 0; tgtArray = 1; tgtOffset = 0; length = 5;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(negedge clock);
            if (wrLog.size() >= 2) break;
        end
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        total++;
        if (busy !== 1'b0 || heapWrEn !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_mid_idle: busy=%b heapWrEn=%b done=%b expected 0/0/0", busy, heapWrEn, done);
        end
        repeat (6) @(negedge clock);
        total++;
        if (wrLog.size() != 2 || doneCount != dc0) begin
            bad++; $display("FAIL reset_mid_writes: writes=%0d dones=%0d expected 2 and 0", wrLog.size(), doneCount - dc0);
        end
        total++;
        if (heap[10] !== W'(0) || heap[11] !== W'(1) || heap[12] !== W'(102) || heap[13] !== W'(103)) begin
            bad++; $display("FAIL reset_mid_heap: got %0d %0d %0d %0d expected 0 1 102 103",
                            heap[10], heap[11], heap[12], heap[13]);
        end
        refHeap[10] = 0;
        refHeap[11] = 1;
        run_move(0, 0, 1, 0, 0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        set_mem();
        run_move(0, 4, 1, 2, 3, 1'b1);
        repeat (4) @(negedge clock);
        total++;
        if (busy !== 1'b0 || doneCount == 0) begin
            bad++; $display("FAIL start_ignored: busy=%b after op expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        set_mem();
        run_move(0, 1, 1, 0, 4, 1'b0);
        run_move(1, 0, 0, 5, 3, 1'b0);
        run_move(0, 2, 0, 0, 6, 1'b0);
        run_move(1, 9, 1, 0, 2, 1'b0);
    endtask

    task automatic test_random();
        int sa, so, ta, to, len;
        for (int it = 0; it < 30; it++) begin
            if (it % 5 == 0) rand_mem();
            sa  = ($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(0, 1));
            ta  = ($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(0, 1));
            len = int'($urandom_range(0, 7));
            so  = int'($urandom_range(0, 9));
            to  = int'($urandom_range(0, 9));
            if ($urandom_range(0, 3) != 0) begin
                if (so + len > NArea) so = NArea - len;
                if (to + len > NArea) to = NArea - len;
            end
            run_move(sa, so, ta, to, len, 1'b0);
        end
    endtask

    initial begin
        set_mem();
        test_reset();
        test_basic_copy();
        test_size_grow();
        test_overlap();
        test_zero_and_errors();
        test_reset_mid();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
